vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Pixel-timing stage directly downstream of the clock generator. It runs on the 25 MHz vga_clk and produces 640x480@60 Hz VGA sync, the visible-area flag and pixel coordinates. It also produces a one-cycle frame_end strobe at vblank entry, used as the frame-locked game update tick. The renderer and DAC/pin logic consume its outputs.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, polarity of hsync/vsync while asserted

Ports:
vga_clk  input  1  25 MHz pixel clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
video_on  output  1  1 while the current pixel is inside the visible area
x  output  10  current column, 0..H_TOTAL-1
y  output  10  current row, 0..V_TOTAL-1
line_start  output  1  one-cycle pulse at x==0
frame_start  output  1  one-cycle pulse at x==0, y==0
frame_end  output  1  one-cycle pulse at x==0, y==V_VISIBLE (vblank entry)
rgb  output  8  test-pattern colour {R3,G3,B2}; see Optional Feature

Behaviour:
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both counters are 10-bit.
- Single clock domain: vga_clk. Reset is synchronous and active-high, sampled on the vga_clk rising edge.
- State is two registered counters, h_cnt and v_cnt. x = h_cnt and y = v_cnt directly.
- Every other output is registered and aligned so that it describes the same (x,y) as x/y in the same cycle. Decode from next-count values; no combinational glitches are allowed on hsync or vsync.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
- v_cnt wraps from V_TOTAL-1 to 0 when h_cnt wraps.
- Simultaneous wrap at (799,524) goes to (0,0).
- hsync is asserted (==SYNC_ACTIVE) for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, i.e. x 656..751.
- vsync is asserted for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, i.e. y 490..491, across entire lines.
- video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- Pulse outputs are high for exactly one cycle per event:
  - line_start: 800 cycles apart.
  - frame_start and frame_end: 420000 cycles apart.
- Reset values, held while rst=1: h_cnt=0, v_cnt=0, hsync=vsync=~SYNC_ACTIVE, video_on=0, all pulses 0, rgb=0.
- First cycle after rst deasserts: x=0, y=0, video_on=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: the outputs above take effect on the next edge, with no partial line or pulse after that edge. Restart is identical to power-up.
- rst held for N cycles: outputs stay static for N cycles.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: rgb drives 8 vertical colour bars, each H_VISIBLE/8 = 80 pixels wide, selected by x[9:0]/80. Order: white FF, yellow FC, cyan 1F, green 1C, magenta E3, red E0, blue 03, black 00. rgb is registered and aligned with x/y. rgb is 00 whenever video_on=0.
- Undefined: rgb is constant 8'h00 and no bar logic is synthesised.

Test Plan:
- Reset release: hold rst 5 cycles, then release -> first cycle x=0, y=0, video_on=1, frame_start=1, line_start=1, hsync=vsync=1.
- Line timing: run one line -> video_on falls at x=640; hsync=0 exactly for x 656..751 (96 cycles); line_start recurs 800 cycles after the first.
- Frame timing: run 2 frames -> vsync low for exactly 1600 cycles starting at (0,490); frame_end at (0,480); frame_start period 420000 cycles.
- Wrap: observe (799,524) -> next cycle is (0,0) with frame_start=1; x and y never reach 800 or 525.
- Mid-frame reset: assert rst at (300,200) for 1 cycle -> next cycle matches reset values; first cycle after release matches the reset-release scenario; no stray frame_end.
- Test pattern (with VGA_TEST_PATTERN_EN): y=10 -> rgb=FF at x=0, FC at x=80, 00 at x=639, 00 at x=700. Without the macro -> rgb=00 everywhere.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA pixel-timing stage: sync, visible flag,
// pixel coordinates, line/frame pulses and test-pattern colour.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] rgb;

  modport master (
    output hsync, vsync, video_on, x, y,
    output line_start, frame_start, frame_end, rgb
  );

  modport slave (
    input hsync, vsync, video_on, x, y,
    input line_start, frame_start, frame_end, rgb
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator on the 25 MHz pixel clock.
// Two counters (h_cnt, v_cnt) drive x/y directly; every other output is
// decoded from the next-count values and registered, so all outputs describe
// the same pixel in the same cycle and sync lines are glitch-free.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic           vga_clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  // Low while in reset and for the first edge after it, so that the first
  // post-reset cycle presents pixel (0,0) rather than (1,0).
  logic       run;

  logic hs_nxt, vs_nxt, vis_nxt, ls_nxt, fs_nxt, fe_nxt;
  logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q, frame_end_q;

  // Next pixel position: hold at (0,0) until running, then raster scan.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
      end
    end
  end

  // Decode the next position so the registered outputs line up with x/y.
  always_comb begin
    hs_nxt  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
    vs_nxt  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
    vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    ls_nxt  = (h_nxt == 10'd0);
    fs_nxt  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    fe_nxt  = (h_nxt == 10'd0) && (v_nxt == V_VIS);
  end

  // Counter and timing-output registers; reset forces the idle state.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      run           <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      run           <= 1'b1;
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hsync_q       <= hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q       <= vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_q    <= vis_nxt;
      line_start_q  <= ls_nxt;
      frame_start_q <= fs_nxt;
      frame_end_q   <= fe_nxt;
    end
  end

  assign vga.x           = h_cnt;
  assign vga.y           = v_cnt;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_end   = frame_end_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;

  // Colour of the vertical bar containing column col.
  function automatic logic [7:0] bar_colour(input logic [9:0] col);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (col >= 10'(i * BAR_W)) idx = 3'(i);
    end
    case (idx)
      3'd0:    bar_colour = 8'hFF;
      3'd1:    bar_colour = 8'hFC;
      3'd2:    bar_colour = 8'h1F;
      3'd3:    bar_colour = 8'h1C;
      3'd4:    bar_colour = 8'hE3;
      3'd5:    bar_colour = 8'hE0;
      3'd6:    bar_colour = 8'h03;
      default: bar_colour = 8'h00;
    endcase
  endfunction

  logic [7:0] rgb_q;

  // Colour register, blanked outside the visible area.
  always_ff @(posedge vga_clk) begin
    if (rst) rgb_q <= 8'h00;
    else     rgb_q <= vis_nxt ? bar_colour(h_nxt) : 8'h00;
  end

  assign vga.rgb = rgb_q;
`else
  assign vga.rgb = 8'h00;
`endif

endmodule
